// File: rtl/glb_psum_gather.sv
// glb_psum_gather: round-robin gather of PE column psums into one tagged output stream
// with FIFO buffering and per-pass word counting.
module glb_psum_gather #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic [NUM_COL-1:0]            col_en,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          psum_total,
    input  logic [NUM_COL-1:0]            pe_valid,
    input  logic [NUM_COL*DATA_WIDTH-1:0] pe_data,
    output logic [NUM_COL-1:0]            pe_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_COL)-1:0]    out_col,
    output logic                          busy,
    output logic                          done
);
    localparam int CW = $clog2(NUM_COL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CW + DATA_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nx;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic [CNT_WIDTH-1:0] total, acc_cnt, out_cnt;
    logic [CW-1:0]        rr, win;
    logic [NUM_COL-1:0]   cand;
    logic                 found, can_grant, push, pop, last_pop, done_nx;

    assign cand      = pe_valid & col_en;
    assign can_grant = (state == RUN) && !flush && (count < (AW+1)'(FIFO_DEPTH)) && (acc_cnt < total);
    assign push      = found && can_grant;
    assign pe_ready  = push ? NUM_COL'(1) << win : '0;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
    assign out_col   = out_valid ? head[EW-1 -: CW] : '0;
    assign busy      = state == RUN;
    assign last_pop  = (state == RUN) && pop && (out_cnt == total - CNT_WIDTH'(1));

    // first enabled, valid column at or above the rr pointer, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_COL; k++) begin
            if (!found && cand[(int'(rr) + k) % NUM_COL]) begin
                found = 1'b1;
                win   = CW'((int'(rr) + k) % NUM_COL);
            end
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        if (flush) begin
            state_nx = IDLE;
        end else if (state == IDLE && start) begin
            state_nx = (psum_total != '0) ? RUN : IDLE;
            done_nx  = psum_total == '0;
        end else if (last_pop) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            total   <= '0;
            acc_cnt <= '0;
            out_cnt <= '0;
            rr      <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            total   <= '0;
            acc_cnt <= '0;
            out_cnt <= '0;
            rr      <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 1'b1;
                rr      <= (win == CW'(NUM_COL - 1)) ? '0 : win + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (pop && state == RUN) out_cnt <= out_cnt + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == IDLE && start) begin
                total   <= psum_total;
                acc_cnt <= '0;
                out_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {win, pe_data[win*DATA_WIDTH +: DATA_WIDTH]};
    end
endmodule

// File: tb/tb_glb_psum_gather.sv
// tb_glb_psum_gather: scoreboard bench with a cycle model of grants, FIFO contents and pass control.
module tb_glb_psum_gather;
    logic        clk = 1'b0;
    logic        rstn, flush, start, out_ready, out_valid, busy, done;
    logic [7:0]  col_en, pe_valid, pe_ready;
    logic [15:0] psum_total, out_data;
    logic [127:0] pe_data;
    logic [2:0]  out_col;

    int checks = 0, errors = 0;
    int seq [8];
    int colcnt [8];
    int n_acc, n_pop;
    logic [18:0] q [$];
    logic [18:0] held;
    logic [7:0]  acc;
    bit m_run, exp_done, hold;
    int m_total, m_acc, m_outc, m_rr;

    glb_psum_gather dut (
        .clk(clk), .rstn(rstn), .flush(flush), .col_en(col_en), .start(start),
        .psum_total(psum_total), .pe_valid(pe_valid), .pe_data(pe_data), .pe_ready(pe_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 8; i++) pe_data[i*16 +: 16] = 16'h0011 + 16'(i*256) + 16'(seq[i]);
    endtask

    task automatic model_clear();
        q.delete();
        m_run = 0; m_acc = 0; m_outc = 0; m_rr = 0; m_total = 0;
        exp_done = 0; hold = 0;
    endtask

    task automatic step();
        logic [7:0] cand, expr;
        logic [18:0] e;
        int w, a;
        bit f, p;
        @(negedge clk);
        check("busy", busy, m_run);
        check("done", done, exp_done);
        check("out_valid", out_valid, q.size() != 0);
        if (hold) check("hold", {out_valid, out_col, out_data}, {1'b1, held});
        cand = pe_valid & col_en;
        expr = 0; f = 0; w = 0;
        if (m_run && m_acc < m_total && q.size() < 8) begin
            for (int k = 0; k < 8; k++) begin
                int j = (m_rr + k) % 8;
                if (!f && cand[j]) begin f = 1; w = j; end
            end
            if (f) expr = 8'b1 << w;
        end
        if (!flush) check("pe_ready", pe_ready, expr);
        acc = pe_valid & pe_ready;
        hold = out_valid & ~out_ready;
        held = {out_col, out_data};
        exp_done = 0;
        if (flush) begin
            model_clear();
        end else begin
            p = out_valid & out_ready;
            if (p) begin
                if (q.size() == 0) check("spurious_pop", 1, 0);
                else begin
                    e = q.pop_front();
                    check("word", {out_col, out_data}, e);
                end
                n_pop++;
            end
            a = -1;
            for (int i = 0; i < 8; i++) if (acc[i] && a < 0) a = i;
            if (a >= 0) begin
                q.push_back({3'(a), pe_data[a*16 +: 16]});
                colcnt[a]++;
                n_acc++;
            end
            if (m_run) begin
                if (a >= 0) begin m_acc++; m_rr = (a + 1) % 8; end
                if (p) begin
                    m_outc++;
                    if (m_outc == m_total) begin m_run = 0; exp_done = 1; end
                end
            end else if (start) begin
                if (psum_total != 0) begin
                    m_run = 1; m_total = psum_total; m_acc = 0; m_outc = 0;
                end else exp_done = 1;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) if (acc[i]) seq[i]++;
        drive_data();
    endtask

    task automatic do_flush();
        pe_valid = 0; out_ready = 0;
        flush = 1; step(); flush = 0;
        n_acc = 0; n_pop = 0;
        for (int i = 0; i < 8; i++) begin colcnt[i] = 0; seq[i] = 0; end
        drive_data();
    endtask

    task automatic kick(input int t);
        psum_total = 16'(t); start = 1; step(); start = 0;
    endtask

    task automatic finish_pass();
        int c = 0;
        while ((m_run || q.size() != 0 || exp_done) && c < 300) begin step(); c++; end
        check("timeout", m_run || q.size() != 0, 0);
    endtask

    initial begin
        rstn = 0; flush = 0; start = 0; out_ready = 0; col_en = 0; pe_valid = 0; psum_total = 0;
        for (int i = 0; i < 8; i++) begin seq[i] = 0; colcnt[i] = 0; end
        drive_data(); model_clear(); n_acc = 0; n_pop = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        check("rst_out_data", out_data, 0);
        check("rst_out_col", out_col, 0);
        step();

        // single column, with an ignored mid-pass start and extra valid words afterward
        col_en = 8'h01; pe_valid = 8'h01; out_ready = 1;
        kick(4);
        step(); step();
        psum_total = 2; start = 1; step(); start = 0;
        finish_pass();
        repeat (5) step();
        check("single_acc", n_acc, 4);
        check("single_pop", n_pop, 4);
        check("single_col0", colcnt[0], 4);

        // full round robin
        do_flush();
        col_en = 8'hFF; pe_valid = 8'hFF; out_ready = 1;
        kick(16);
        finish_pass();
        for (int i = 0; i < 8; i++) check("rr_percol", colcnt[i], 2);

        // backpressure until the FIFO fills, then drain
        do_flush();
        col_en = 8'hFF; pe_valid = 8'b0010_0101; out_ready = 0;
        kick(20);
        repeat (15) step();
        check("bp_full_acc", n_acc, 8);
        out_ready = 1;
        finish_pass();
        check("bp_acc", n_acc, 20);
        check("bp_pop", n_pop, 20);

        // masked columns
        do_flush();
        col_en = 8'b1010_0101; pe_valid = 8'hFF; out_ready = 1;
        kick(8);
        finish_pass();
        for (int i = 0; i < 8; i++) check("mask_percol", colcnt[i], (8'b1010_0101 >> i) & 1 ? 2 : 0);

        // zero-length pass
        do_flush();
        kick(0);
        step();
        repeat (3) step();
        check("zero_acc", n_acc, 0);

        // flush with five words buffered, then a normal pass
        do_flush();
        col_en = 8'hFF; pe_valid = 8'h03; out_ready = 0;
        kick(10);
        for (int c = 0; c < 30 && n_acc < 5; c++) step();
        check("flush_fill", n_acc, 5);
        pe_valid = 0;
        step();
        do_flush();
        step();
        check("flush_empty", out_valid, 0);
        pe_valid = 8'h01; out_ready = 1;
        kick(3);
        finish_pass();
        check("post_flush_pop", n_pop, 3);

        // asynchronous reset mid-pass
        do_flush();
        col_en = 8'hFF; pe_valid = 8'hFF; out_ready = 0;
        kick(16);
        repeat (4) step();
        #2 rstn = 0;
        #1;
        check("arst_pe_ready", pe_ready, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_col", out_col, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        model_clear();
        pe_valid = 0;
        @(posedge clk);
        #1 rstn = 1;
        step();
        pe_valid = 8'h01; out_ready = 1;
        kick(2);
        finish_pass();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/glb_psum_gather.md
Name: glb_psum_gather

Overview:
- Return-path collector for the global PE set: gathers partial sums from the NUM_COL PE output ports and serialises them onto one Y-direction stream toward the global buffer.
- Forward direction is the X bus broadcast (tag-matched scatter); this block is the matching gather.
- Round-robin arbitration over enabled columns, FIFO buffering, source-column tagging, pass-completion counting.

Parameters:
- DATA_WIDTH, 16, psum word width.
- NUM_COL, 8, number of PE columns/output ports.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2.
- CNT_WIDTH, 16, width of pass word counter.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO, counters, arbiter pointer.
- col_en  in  NUM_COL  per-column enable (driven from tag locks); 0 = column never granted.
- start  in  1  one-cycle pulse; loads psum_total and begins a pass.
- psum_total  in  CNT_WIDTH  words expected in this pass.
- pe_valid  in  NUM_COL  column i has a psum.
- pe_data  in  NUM_COL*DATA_WIDTH  column i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- pe_ready  out  NUM_COL  one-hot grant; column i word accepted when pe_valid[i] & pe_ready[i].
- out_valid  out  1  head-of-FIFO word available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  psum word.
- out_col  out  $clog2(NUM_COL)  source column of out_data.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse when last word of pass leaves out port.

Behaviour:
- Reset (rstn=0, async): pe_ready=0, out_valid=0, out_data=0, out_col=0, busy=0, done=0; FIFO empty; rr pointer=0; counters=0.
- States: IDLE, RUN. IDLE: pe_ready=0. start in IDLE: psum_total>0 -> RUN, busy=1 next cycle, acc_cnt=out_cnt=0; psum_total=0 -> done pulse next cycle, stay IDLE. start in RUN ignored.
- Arbitration (RUN, combinational): candidates = pe_valid & col_en. Grant allowed only when FIFO occupancy < FIFO_DEPTH and acc_cnt < total. Winner = first candidate searching from rr pointer upward, wrapping at NUM_COL. pe_ready one-hot on winner, else all 0. pe_ready never asserted to a column with pe_valid=0 or col_en=0.
- On accept: push {column index, word}; acc_cnt+1; rr pointer = winner+1 mod NUM_COL. No accept -> pointer holds.
- FIFO: registered; word accepted in cycle N visible on out_valid/out_data/out_col in cycle N+1 (min latency 1). No full-case bypass: at full no push even if pop same cycle. Push+pop same cycle when non-empty: occupancy unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Output: out_data/out_col held stable while out_valid & ~out_ready. Pop on out_valid & out_ready; out_cnt+1.
- Completion: pop making out_cnt == total -> done=1 next cycle for exactly 1 cycle, busy=0 same cycle, state IDLE. acc_cnt == total stops further grants (extra PE words stay pending).
- flush (sync, priority over all except reset): next cycle FIFO empty, out_valid=0, counters 0, pointer 0, IDLE, busy=0, no done pulse.
- col_en change mid-pass: takes effect on next arbitration cycle; words already in FIFO unaffected.
- Reset mid-pass: immediate return to reset values; in-flight words discarded.

Test Plan:
- Single column: col_en=8'h01, start psum_total=4, pe_valid[0] held with data 0x0011..0x0014, out_ready=1 -> out_data 0x0011..0x0014 in order, out_col=0, first out_valid 1 cycle after first accept, done one pulse after 4th pop, busy low same cycle.
- Round-robin: col_en=8'hFF, all pe_valid=1, psum_total=16 -> grant order col 0,1,...,7,0,...,7; out_col sequence matches; each column exactly 2 words.
- Backpressure/full: FIFO_DEPTH=8, out_ready=0, 3 columns valid, psum_total=20 -> exactly 8 accepts then pe_ready=0; out_data stable; releasing out_ready -> remaining 12 delivered, no loss or duplication.
- Masking: col_en=8'b1010_0101, all valid, psum_total=8 -> grants only cols 0,2,5,7 in cyclic order; cols 1,3,4,6 never see pe_ready.
- Limits: psum_total=0 start -> done next cycle, busy never 1; start during RUN ignored; valid words beyond total never accepted.
- Flush/reset: flush with 5 words buffered -> out_valid=0 next cycle, no done; new start works normally. rstn low mid-pass -> all outputs 0 asynchronously.
